inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
Sequences the instruction ROM for the fetch stage. It owns the fetch PC, drives the ROM chip-enable and address, and captures each returned word together with its PC into a small prefetch FIFO. It presents fetched instructions to the decode stage through a valid/ready handshake. On a branch or jump redirect it flushes the FIFO and restarts fetch from the new target.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, prefetch FIFO entries (power of two, 2..16).
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_ce  out  1  ROM chip enable; the ROM returns 0 when this is low.
- rom_addr  out  32  byte address to the ROM (word index = addr[11:2]).
- rom_inst  in  32  combinational ROM data for the current rom_addr.
- redirect  in  1  one-cycle pulse: flush the FIFO and restart fetch.
- redirect_pc  in  32  target address, sampled when redirect=1.
- inst_valid  out  1  FIFO head holds a valid instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- inst  out  32  head instruction word.
- inst_pc  out  32  PC of the head instruction.
- fifo_count  out  PTR_W+1  number of occupied entries (debug/perf).

Behaviour:
- Reset (rst=1 at the clock edge):
  - state=BOOT, pc_reg=RESET_PC, FIFO pointers and count=0.
  - Outputs: rom_ce=0, inst_valid=0, inst=0, inst_pc=0, fifo_count=0.
  - Reset asserted mid-fetch discards all entries. No pending handshake survives.
- FSM:
  - BOOT: rom_ce=0. Goes to RUN on the first clock with rst=0, so the first fetch happens one cycle after reset release.
  - RUN: normal fetching. There is no other state.
- Combinational ROM interface:
  - rom_addr = pc_reg, with bits [1:0] always 0.
  - rom_ce = (state==RUN) && (space || pop), where space = fifo_count<DEPTH and pop = inst_valid && inst_ready.
- Push condition: rom_ce && !redirect.
  - Writes {rom_inst, pc_reg} at the tail.
  - pc_reg <= pc_reg+4, wrapping mod 2^32 (32'hFFFF_FFFC -> 0).
- Pop: the head advances when pop=1.
- Push and pop in the same cycle:
  - fifo_count is unchanged.
  - This is allowed even when full, so steady-state throughput is 1 instruction/cycle.
- Full FIFO and no pop: rom_ce=0, pc_reg holds, no push.
- Empty FIFO: inst_valid=0. inst and inst_pc read 0 (not stale data). A push in this cycle becomes visible the next cycle, so fetch-to-valid latency is 1 cycle.
- redirect=1:
  - pc_reg <= {redirect_pc[31:2], 2'b00}. Misaligned targets are silently aligned.
  - FIFO is cleared and count=0.
  - No push this cycle, and a pop in the same cycle is ignored (the entry is discarded). inst_valid is still driven that cycle from the current count; decode must ignore it.
  - The first instruction from the target is valid 2 cycles after the redirect edge.
- redirect while in BOOT: pc_reg is loaded, and fetch starts from the target on entry to RUN.
- Back-to-back redirects: the last one wins.
- Holding rules:
  - inst and inst_pc stay stable while inst_valid=1 and inst_ready=0.
  - inst_ready is a don't-care when inst_valid=0.

Test Plan:
- Reset release with RESET_PC=0 and ROM word i = 32'h1000_0000+i, inst_ready=1:
  - rom_ce rises 1 cycle after rst falls.
  - inst_valid rises 1 cycle later with inst=32'h1000_0000, inst_pc=0.
  - Then pc 4, 8, 12, ... arrive one per cycle.
- Hold inst_ready=0 for 10 cycles after reset:
  - fifo_count saturates at 4, rom_ce=0, rom_addr holds at 16.
  - Head stays inst_pc=0.
  - On releasing ready, PCs 0, 4, 8, 12, 16 come out in order with no gap and no duplicate.
- Full FIFO with inst_ready=1 steady: fifo_count stays 4 while one word is pushed and one popped per cycle; PCs stay consecutive.
- redirect=1 with redirect_pc=32'h0000_0043 while 3 entries are queued:
  - Next cycle: fifo_count=0, inst_valid=0, rom_addr=32'h40.
  - Following cycle: inst_pc=32'h40 with inst=ROM[16].
- pc_reg forced via redirect to 32'hFFFF_FFFC: the next fetched inst_pc sequence is FFFF_FFFC, 0000_0000, 0000_0004.
- rst asserted with 2 entries queued and redirect=1 in the same cycle:
  - Next cycle: inst_valid=0, fifo_count=0, rom_ce=0, pc_reg=RESET_PC.
  - The redirect is ignored.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
//   Fetch-stage sequencer. Owns the fetch PC, drives the instruction ROM and
//   buffers returned words (with their PCs) in a small prefetch FIFO that the
//   decode stage drains through a valid/ready handshake. A redirect flushes the
//   FIFO and restarts fetch from the (word-aligned) target.
//
//   Ports
//     clk          system clock, all state on the rising edge
//     rst          synchronous active-high reset
//     rom_ce       ROM chip enable (combinational)
//     rom_addr     ROM byte address, always word aligned
//     rom_inst     combinational ROM read data for rom_addr
//     redirect     one-cycle flush/restart pulse
//     redirect_pc  restart target, low two bits ignored
//     inst_valid   FIFO head is valid
//     inst_ready   decode accepts the head this cycle
//     inst         head instruction word (0 when empty)
//     inst_pc      head instruction PC (0 when empty)
//     fifo_count   occupied FIFO entries
// -----------------------------------------------------------------------------
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             rom_ce,
  output logic [31:0]      rom_addr,
  input  logic [31:0]      rom_inst,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic [PTR_W:0]   fifo_count
);

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  state_t           state;
  logic [31:0]      pc_reg;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [31:0]      mem_inst [DEPTH];
  logic [31:0]      mem_pc   [DEPTH];

  logic space;
  logic pop;
  logic push;

  // Misaligned targets are silently aligned, so the low bits are dropped.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign space      = (count < FULL_COUNT);
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;

  // Fetch whenever there is room, or when the head leaves this very cycle;
  // the latter keeps a full FIFO streaming at one instruction per cycle.
  assign rom_ce   = (state == RUN) && (space || pop);
  assign rom_addr = pc_reg;
  assign push     = rom_ce && !redirect;

  // An empty FIFO presents zeros rather than whatever the head slot last held.
  assign inst       = inst_valid ? mem_inst[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? mem_pc[rd_ptr]   : '0;
  assign fifo_count = count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= BOOT;
      pc_reg <= {RESET_PC[31:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (state == BOOT) begin
        state <= RUN;
      end

      if (redirect) begin
        // Flush wins over any same-cycle pop; the head is simply discarded.
        pc_reg <= {redirect_pc[31:2], 2'b00};
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc_reg <= pc_reg + 32'd4;
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by the reset
  // pointers/count and empty reads are masked, so stale contents never leak.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= rom_inst;
      mem_pc[wr_ptr]   <= pc_reg;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
//   Directed bench for inst_fetch_ctrl. A behavioural ROM returns
//   32'h1000_0000 + word index. Expected head PCs are queued as stimulus is
//   applied; a negedge monitor pops and compares on every accepted handshake.
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [2:0]  fifo_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb_q [$];

  inst_fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4),
    .PTR_W    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce      (rom_ce),
    .rom_addr    (rom_addr),
    .rom_inst    (rom_inst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h1000_0000 + {22'b0, addr[11:2]};
  endfunction

  assign rom_inst = rom_ce ? rom_word(rom_addr) : 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(start + 32'(4 * i));
    end
  endtask

  // Scoreboard monitor: a handshake seen at negedge completes at the next edge
  // unless reset or redirect discards it.
  always @(negedge clk) begin
    logic [31:0] exp_pc;
    if (!rst && !redirect && inst_valid && inst_ready && sb_q.size() > 0) begin
      exp_pc = sb_q.pop_front();
      check("pop_pc", inst_pc, exp_pc);
      check("pop_inst", inst, rom_word(exp_pc));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = 1'b1;

    // Reset state and first fetch latency.
    step();
    step();
    check("rst_rom_ce", 32'(rom_ce), 32'h0);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    rst = 1'b0;
    expect_run(32'h0, 8);
    check("boot_rom_ce", 32'(rom_ce), 32'h0);
    step();
    check("run_rom_ce", 32'(rom_ce), 32'h1);
    check("run_valid", 32'(inst_valid), 32'h0);
    check("run_addr", rom_addr, 32'h0);
    step();
    check("first_valid", 32'(inst_valid), 32'h1);
    check("first_pc", inst_pc, 32'h0);
    check("first_inst", inst, 32'h1000_0000);
    repeat (8) step();
    check("stream_drain", 32'(sb_q.size()), 32'h0);

    // Back-pressure: FIFO fills and holds, then drains with no gap.
    rst        = 1'b1;
    inst_ready = 1'b0;
    step();
    rst = 1'b0;
    repeat (11) step();
    check("full_count", 32'(fifo_count), 32'h4);
    check("full_rom_ce", 32'(rom_ce), 32'h0);
    check("full_addr", rom_addr, 32'h10);
    check("hold_valid", 32'(inst_valid), 32'h1);
    check("hold_pc", inst_pc, 32'h0);
    check("hold_inst", inst, 32'h1000_0000);
    inst_ready = 1'b1;
    expect_run(32'h0, 12);
    for (int i = 0; i < 12; i++) begin
      step();
      check("steady_count", 32'(fifo_count), 32'h4);
      check("steady_valid", 32'(inst_valid), 32'h1);
    end
    check("steady_drain", 32'(sb_q.size()), 32'h0);

    // Redirect with three queued entries and a misaligned target.
    rst        = 1'b1;
    inst_ready = 1'b0;
    step();
    rst = 1'b0;
    repeat (4) step();
    check("pre_redir_count", 32'(fifo_count), 32'h3);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0043;
    inst_ready  = 1'b1;
    expect_run(32'h40, 4);
    step();
    redirect = 1'b0;
    check("redir_count", 32'(fifo_count), 32'h0);
    check("redir_valid", 32'(inst_valid), 32'h0);
    check("redir_addr", rom_addr, 32'h40);
    step();
    check("redir_first_valid", 32'(inst_valid), 32'h1);
    check("redir_first_pc", inst_pc, 32'h40);
    check("redir_first_inst", inst, 32'h1000_0010);
    repeat (4) step();
    check("redir_drain", 32'(sb_q.size()), 32'h0);

    // PC wrap at the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    sb_q.push_back(32'hFFFF_FFFC);
    sb_q.push_back(32'h0000_0000);
    sb_q.push_back(32'h0000_0004);
    step();
    redirect = 1'b0;
    check("wrap_addr", rom_addr, 32'hFFFF_FFFC);
    repeat (5) step();
    check("wrap_drain", 32'(sb_q.size()), 32'h0);

    // Reset beats a same-cycle redirect and discards queued entries.
    inst_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    repeat (2) step();
    check("pre_rst_count", 32'(fifo_count), 32'h2);
    rst         = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    check("rst_redir_valid", 32'(inst_valid), 32'h0);
    check("rst_redir_count", 32'(fifo_count), 32'h0);
    check("rst_redir_rom_ce", 32'(rom_ce), 32'h0);
    check("rst_redir_pc", rom_addr, 32'h0);
    rst        = 1'b0;
    redirect   = 1'b0;
    inst_ready = 1'b1;
    expect_run(32'h0, 3);
    repeat (5) step();
    check("post_rst_drain", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
